// File: rtl/popcount_sched.sv
// popcount_sched: round-robin scheduler sharing one pipelined popcount tree
// among NREQ requesters. One W-bit vector is accepted per clock. Its requester
// ID, a valid bit and the threshold in force at issue travel in a sideband
// shift register in lockstep with the tree. The count, ID and a match flag
// (count <= threshold) come back a fixed LAT = log2(W)+2 edges after the
// transfer edge.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             when low no new grants; work already accepted completes
//   req_valid      per-requester request valid            [NREQ]
//   req_data       requester i vector at [i*W +: W]         [NREQ*W]
//   req_ready      one-hot (or zero) grant                  [NREQ]
//   cfg_thresh_we  load cfg_thresh into the match threshold
//   cfg_thresh     threshold value                          [SW]
//   res_valid      one-cycle result strobe per accepted request
//   res_id         requester index of the result            [IDW]
//   res_count      number of set bits                       [SW]
//   res_match      res_count <= threshold sampled at issue
//   busy           some accepted request has not yet returned

// Pipelined popcount tree with log2(W) register levels. It has no reset and
// no valid; the surrounding scheduler tracks validity separately.
module binary_adder_tree #(
    parameter int W  = 128,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic [W-1:0]  vec,
    output logic [SW-1:0] count
);
    localparam int L = $clog2(W);

    // Level k holds W>>k partial sums, each k+1 bits wide, which is exactly
    // enough to hold the popcount of the 2**k input bits it covers.
    for (genvar k = 1; k <= L; k++) begin : lvl
        localparam int N = W >> k;
        logic [k:0] sum [N];
        if (k == 1) begin : leaf
            always_ff @(posedge clk) begin
                for (int j = 0; j < N; j++) begin
                    sum[j] <= {1'b0, vec[2*j]} + {1'b0, vec[2*j+1]};
                end
            end
        end else begin : inner
            always_ff @(posedge clk) begin
                for (int j = 0; j < N; j++) begin
                    sum[j] <= {1'b0, lvl[k-1].sum[2*j]} + {1'b0, lvl[k-1].sum[2*j+1]};
                end
            end
        end
    end

    assign count = SW'(lvl[L].sum[0]);
endmodule

module popcount_sched #(
    parameter int W          = 128,
    parameter int SW         = 8,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int THRESH_RST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    input  logic            cfg_thresh_we,
    input  logic [SW-1:0]   cfg_thresh,
    output logic            res_valid,
    output logic [IDW-1:0]  res_id,
    output logic [SW-1:0]   res_count,
    output logic            res_match,
    output logic            busy
);
    localparam int L = $clog2(W);

    logic [IDW-1:0]  last;
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] pick_vec;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [W-1:0]    sel_data;
    logic            transfer;

    logic [SW-1:0]   thresh;

    logic            iss_valid;
    logic [IDW-1:0]  iss_id;
    logic [SW-1:0]   iss_thr;
    logic [W-1:0]    iss_data;

    logic [L-1:0]    sb_valid;
    logic [IDW-1:0]  sb_id  [L];
    logic [SW-1:0]   sb_thr [L];

    logic [SW-1:0]   tree_count;

    // Round robin: requesters above the last grant are searched first; if
    // none of them is asking, the search wraps to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i > int'(last));
        end
    end

    always_comb begin
        pick_vec  = ((req_valid & hi_mask) != '0) ? (req_valid & hi_mask) : req_valid;
        grant     = '0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end

    // Grants are also suppressed while reset is held so req_ready reads zero
    // immediately on reset assertion.
    assign req_ready = (en && !rst) ? grant : '0;
    assign transfer  = |req_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*W +: W];
            end
        end
    end

    // last starts at NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= IDW'(NREQ - 1);
        end else if (transfer) begin
            last <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh <= SW'(THRESH_RST);
        end else if (cfg_thresh_we) begin
            thresh <= cfg_thresh;
        end
    end

    // Idle cycles load zero data so the tree never sees stale or undefined
    // vectors; validity alone decides whether a result is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_thr   <= '0;
            iss_data  <= '0;
        end else if (transfer) begin
            iss_valid <= 1'b1;
            iss_id    <= grant_idx;
            iss_thr   <= thresh;
            iss_data  <= sel_data;
        end else begin
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_thr   <= '0;
            iss_data  <= '0;
        end
    end

    binary_adder_tree #(.W(W), .SW(SW)) u_tree (
        .clk   (clk),
        .vec   (iss_data),
        .count (tree_count)
    );

    // Sideband is L deep, matching the tree's register levels, so stage L-1
    // lines up with tree_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            for (int i = 0; i < L; i++) begin
                sb_id[i]  <= '0;
                sb_thr[i] <= '0;
            end
        end else begin
            sb_valid[0] <= iss_valid;
            sb_id[0]    <= iss_id;
            sb_thr[0]   <= iss_thr;
            for (int i = 1; i < L; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_id[i]    <= sb_id[i-1];
                sb_thr[i]   <= sb_thr[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_count <= '0;
            res_match <= 1'b0;
        end else if (sb_valid[L-1]) begin
            res_valid <= 1'b1;
            res_id    <= sb_id[L-1];
            res_count <= tree_count;
            res_match <= (tree_count <= sb_thr[L-1]);
        end else begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_count <= '0;
            res_match <= 1'b0;
        end
    end

    assign busy = iss_valid | (|sb_valid) | res_valid;
endmodule

// File: tb/tb_popcount_sched.sv
// Directed testbench for popcount_sched (W=128, NREQ=4, LAT=9). Inputs are
// driven 1 time unit after the rising edge; a negedge monitor logs grants and
// results with the cycle number so each test task can check ordering and
// latency against hand-computed values.
module tb_popcount_sched;
    localparam int W    = 128;
    localparam int SW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              cfg_thresh_we;
    logic [SW-1:0]     cfg_thresh;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [SW-1:0]     res_count;
    logic              res_match;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {int cyc; int id;} gnt_t;
    typedef struct {int cyc; int id; int count; bit match;} res_t;
    gnt_t gnt_q[$];
    res_t res_q[$];

    popcount_sched #(.W(W), .SW(SW), .NREQ(NREQ), .IDW(IDW), .THRESH_RST(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cfg_thresh_we (cfg_thresh_we),
        .cfg_thresh    (cfg_thresh),
        .res_valid     (res_valid),
        .res_id        (res_id),
        .res_count     (res_count),
        .res_match     (res_match),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) gnt_q.push_back('{cyc, i});
        end
        if (res_valid) res_q.push_back('{cyc, int'(res_id), int'(res_count), res_match});
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        gnt_q.delete();
        res_q.delete();
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] v);
        req_data[idx*W +: W] = v;
    endtask

    task automatic pulse_reset();
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req_valid = 4'b0011; req_data = '0;
        cfg_thresh_we = 1'b0; cfg_thresh = '0;
        #3;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
        vectors++; if (res_id !== 2'd0 || res_count !== 8'd0 || res_match !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_res_fields: got id=%0d count=%0d match=%b expected 0/0/0", res_id, res_count, res_match); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        step(2);
        rst = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL reset_first_grant: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        int busy_bad = 0;
        clear_logs();
        step(1);
        set_data(0, 128'hF);
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        set_data(0, '0);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
        end
        vectors++; if (busy_bad !== 0) begin miscompares++; $display("[TB] FAIL single_busy_hold: got %0d low cycles expected 0", busy_bad); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL single_idle_after: got busy=%b res_valid=%b expected 0/0", busy, res_valid); end
        step(3);
        vectors++; if (res_q.size() !== 1 || gnt_q.size() !== 1) begin
            miscompares++; $display("[TB] FAIL single_count: got %0d results %0d grants expected 1/1", res_q.size(), gnt_q.size());
        end else begin
            vectors++; if (res_q[0].cyc - gnt_q[0].cyc !== LAT) begin miscompares++; $display("[TB] FAIL single_latency: got %0d expected %0d", res_q[0].cyc - gnt_q[0].cyc, LAT); end
            vectors++; if (res_q[0].id !== 0 || res_q[0].count !== 4 || res_q[0].match !== 1'b0) begin
                miscompares++; $display("[TB] FAIL single_result: got id=%0d count=%0d match=%b expected 0/4/0", res_q[0].id, res_q[0].count, res_q[0].match); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        set_data(2, {W{1'b1}});
        req_valid = 4'b0100;
        step(1);
        set_data(2, '0);
        step(1);
        req_valid = '0;
        step(14);
        vectors++; if (res_q.size() !== 2) begin
            miscompares++; $display("[TB] FAIL b2b_count: got %0d results expected 2", res_q.size());
        end else begin
            vectors++; if (res_q[0].count !== 128 || res_q[1].count !== 0) begin
                miscompares++; $display("[TB] FAIL b2b_counts: got %0d,%0d expected 128,0", res_q[0].count, res_q[1].count); end
            vectors++; if (res_q[0].id !== 2 || res_q[1].id !== 2) begin
                miscompares++; $display("[TB] FAIL b2b_ids: got %0d,%0d expected 2,2", res_q[0].id, res_q[1].id); end
            vectors++; if (res_q[1].cyc - res_q[0].cyc !== 1) begin
                miscompares++; $display("[TB] FAIL b2b_gap: got %0d expected 1", res_q[1].cyc - res_q[0].cyc); end
            vectors++; if (res_q[0].match !== 1'b0 || res_q[1].match !== 1'b1) begin
                miscompares++; $display("[TB] FAIL b2b_match: got %b,%b expected 0,1", res_q[0].match, res_q[1].match); end
        end
    endtask

    task automatic test_round_robin();
        int exp_id [8]    = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_count [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        pulse_reset();
        clear_logs();
        set_data(0, 128'h1); set_data(1, 128'h3); set_data(2, 128'h7); set_data(3, 128'hF);
        req_valid = 4'b1111;
        step(8);
        req_valid = '0;
        req_data  = '0;
        step(14);
        vectors++; if (gnt_q.size() !== 8 || res_q.size() !== 8) begin
            miscompares++; $display("[TB] FAIL rr_count: got %0d grants %0d results expected 8/8", gnt_q.size(), res_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++; if (gnt_q[i].id !== exp_id[i]) begin
                    miscompares++; $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", i, gnt_q[i].id, exp_id[i]); end
                vectors++; if (res_q[i].id !== exp_id[i] || res_q[i].count !== exp_count[i]) begin
                    miscompares++; $display("[TB] FAIL rr_result[%0d]: got id=%0d count=%0d expected %0d/%0d", i, res_q[i].id, res_q[i].count, exp_id[i], exp_count[i]); end
                vectors++; if (res_q[i].cyc - gnt_q[i].cyc !== LAT) begin
                    miscompares++; $display("[TB] FAIL rr_latency[%0d]: got %0d expected %0d", i, res_q[i].cyc - gnt_q[i].cyc, LAT); end
            end
        end
    endtask

    task automatic test_threshold();
        int exp_count [4] = '{10, 11, 5, 6};
        bit exp_match [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        clear_logs();
        cfg_thresh_we = 1'b1; cfg_thresh = 8'd10;
        step(1);
        cfg_thresh_we = 1'b0;
        set_data(1, 128'h3FF);
        req_valid = 4'b0010;
        step(1);
        set_data(1, 128'h7FF);
        step(1);
        req_valid = '0;
        cfg_thresh_we = 1'b1; cfg_thresh = 8'd5;
        step(1);
        cfg_thresh_we = 1'b0;
        set_data(1, 128'h1F);
        req_valid = 4'b0010;
        step(1);
        set_data(1, 128'h3F);
        step(1);
        req_valid = '0;
        req_data  = '0;
        step(14);
        vectors++; if (res_q.size() !== 4) begin
            miscompares++; $display("[TB] FAIL thr_count: got %0d results expected 4", res_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (res_q[i].count !== exp_count[i] || res_q[i].match !== exp_match[i] || res_q[i].id !== 1) begin
                    miscompares++; $display("[TB] FAIL thr_result[%0d]: got id=%0d count=%0d match=%b expected 1/%0d/%b",
                                            i, res_q[i].id, res_q[i].count, res_q[i].match, exp_count[i], exp_match[i]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_logs();
        set_data(0, 128'hFF);
        req_valid = 4'b0001;
        step(3);
        req_valid = '0;
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rstmid_clear: got busy=%b res_valid=%b expected 0/0", busy, res_valid); end
        step(1);
        rst = 1'b0;
        set_data(0, 128'h7F); set_data(1, 128'hFFFF);
        req_valid = 4'b0011;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin
            miscompares++; $display("[TB] FAIL rstmid_priority: got %b expected 0001", req_ready); end
        step(1);
        req_valid = '0;
        req_data  = '0;
        step(14);
        vectors++; if (gnt_q.size() !== 4 || res_q.size() !== 1) begin
            miscompares++; $display("[TB] FAIL rstmid_count: got %0d grants %0d results expected 4/1", gnt_q.size(), res_q.size());
        end else begin
            vectors++; if (res_q[0].count !== 7 || res_q[0].id !== 0 || res_q[0].match !== 1'b0) begin
                miscompares++; $display("[TB] FAIL rstmid_result: got id=%0d count=%0d match=%b expected 0/7/0", res_q[0].id, res_q[0].count, res_q[0].match); end
            vectors++; if (res_q[0].cyc - gnt_q[3].cyc !== LAT) begin
                miscompares++; $display("[TB] FAIL rstmid_latency: got %0d expected %0d", res_q[0].cyc - gnt_q[3].cyc, LAT); end
        end
    endtask

    task automatic test_enable();
        int ready_bad = 0;
        clear_logs();
        set_data(2, 128'h3);
        req_valid = 4'b0100;
        step(1);
        en = 1'b0;
        req_valid = 4'b1111;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL en_ready_immediate: got %b expected 0000", req_ready); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000) ready_bad++;
        end
        vectors++; if (ready_bad !== 0) begin
            miscompares++; $display("[TB] FAIL en_ready_hold: got %0d granting cycles expected 0", ready_bad); end
        vectors++; if (gnt_q.size() !== 1 || res_q.size() !== 1) begin
            miscompares++; $display("[TB] FAIL en_inflight: got %0d grants %0d results expected 1/1", gnt_q.size(), res_q.size());
        end else begin
            vectors++; if (res_q[0].id !== 2 || res_q[0].count !== 2 || res_q[0].cyc - gnt_q[0].cyc !== LAT) begin
                miscompares++; $display("[TB] FAIL en_inflight_result: got id=%0d count=%0d lat=%0d expected 2/2/%0d",
                                        res_q[0].id, res_q[0].count, res_q[0].cyc - gnt_q[0].cyc, LAT); end
        end
        step(1);
        en = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin
            miscompares++; $display("[TB] FAIL en_resume: got %b expected 1000", req_ready); end
        req_valid = '0;
        req_data  = '0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_threshold();
        test_reset_midflight();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
